// File: rtl/nibble_add_seq_if.sv
// Requester-side bundle for nibble_add_seq: start/done handshake, operands and results.
interface nibble_add_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned WIDTH = 4 * NIBBLES;

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit ripple-carry slice,
// least-significant nibble first, with the inter-nibble carry held in a register.
module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  nibble_add_seq_if.slave    bus
);
  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_fa0;
  logic [1:0]       w_fa1;
  logic [1:0]       w_fa2;
  logic [1:0]       w_fa3;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_ovf;
  logic [WIDTH-1:0] w_sum_ins;

  // One-bit full adder returning {carry_out, sum}
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // Shared 4-bit ripple-carry slice on the low nibble of the operand shifters
  assign w_fa0        = fa(r_a_q[0], r_b_q[0], r_carry);
  assign w_fa1        = fa(r_a_q[1], r_b_q[1], w_fa0[1]);
  assign w_fa2        = fa(r_a_q[2], r_b_q[2], w_fa1[1]);
  assign w_fa3        = fa(r_a_q[3], r_b_q[3], w_fa2[1]);
  assign w_slice_sum  = {w_fa3[0], w_fa2[0], w_fa1[0], w_fa0[0]};
  assign w_slice_cout = w_fa3[1];
  assign w_slice_ovf  = r_a_q[3] ^ r_b_q[3] ^ w_fa3[0] ^ w_fa3[1];

  // Merge the slice result into the nibble selected by idx
  always_comb begin
    w_sum_ins = r_sum;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_sum_ins[4*n +: 4] = w_slice_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath; busy/done are registered from the next state so they track it exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_a_q   <= bus.a;
        r_b_q   <= bus.sub ? ~bus.b : bus.b;
        r_carry <= bus.sub | bus.cin;
        r_idx   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (w_step) begin
        r_sum   <= w_sum_ins;
        r_carry <= w_slice_cout;
        r_a_q   <= r_a_q >> 4;
        r_b_q   <= r_b_q >> 4;
        r_idx   <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_cout <= w_slice_cout;
          r_ovf  <= w_slice_ovf;
        end
      end
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: directed vectors, randomized ops against
// an arithmetic reference, held-start throughput and mid-operation reset.
module tb_nibble_add_seq;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  nibble_add_seq_if #(.NIBBLES(NIB)) bus ();

  nibble_add_seq #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    string        name;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic; returns {ovf, cout, sum}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic c);
    logic [W:0] u;
    logic       co;
    longint     sa, sb, res;
    logic       ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      u   = {1'b0, a} - {1'b0, b};
      co  = (a >= b);
      res = sa - sb;
    end else begin
      u   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      co  = u[W];
      res = sa + sb + longint'(c);
    end
    ov = (res > (2**(W-1)) - 1) || (res < -(2**(W-1)));
    return {ov, co, u[W-1:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c,
                        input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                        input string tag);
    int           lat;
    int           busy_cnt;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    lat       = 0;
    while (!bus.done && lat < 20) begin
      // operand churn while busy must not affect the result
      bus.a = W'($urandom); bus.b = W'($urandom);
      bus.sub = 1'($urandom); bus.cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cnt++;
    end
    chk({tag, ".latency"}, lat, int'(NIB));
    chk({tag, ".sum"},  32'(bus.sum),  32'(e_sum));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(e_cout));
    chk({tag, ".ovf"},  32'(bus.ovf),  32'(e_ovf));
    @(posedge clk); #1;
    chk({tag, ".busy_cycles"}, busy_cnt, int'(NIB) + 1);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 0);
    chk({tag, ".done_pulse"}, 32'(bus.done), 0);
    chk({tag, ".hold_sum"}, 32'(bus.sum), 32'(e_sum));
  endtask

  task automatic run_rand(input string tag);
    logic [W-1:0] a, b;
    logic         s, c;
    logic [W+1:0] e;
    a = W'($urandom); b = W'($urandom);
    s = 1'($urandom); c = 1'($urandom);
    e = ref_op(a, b, s, c);
    run_op(a, b, s, c, e[W-1:0], e[W], e[W+1], tag);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] ha[0:19];
    logic [W-1:0] hb[0:19];
    logic         hs[0:19];
    logic         hc[0:19];
    logic [W+1:0] e;
    int           ndone;
    int           k;
    int           spurious;

    vecs.push_back('{16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, "add"});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, "add_cin"});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, "sub_noborrow"});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add"});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "ovf_sub"});

    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.done", 32'(bus.done), 0);
    chk("reset.sum",  32'(bus.sum),  0);
    chk("reset.cout", 32'(bus.cout), 0);
    chk("reset.ovf",  32'(bus.ovf),  0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].name);
    end

    for (int i = 0; i < 40; i++) begin
      run_rand($sformatf("rand%0d", i));
    end

    // Held start: captures every NIB+2 cycles, each using only its capture-edge operands
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      ha[cyc] = W'($urandom); hb[cyc] = W'($urandom);
      hs[cyc] = 1'($urandom); hc[cyc] = 1'($urandom);
      bus.a = ha[cyc]; bus.b = hb[cyc]; bus.sub = hs[cyc]; bus.cin = hc[cyc];
      bus.start = 1'b1;
      @(posedge clk); #1;
      if (bus.done) begin
        chk($sformatf("hold.done_cycle%0d", ndone), cyc, int'(NIB) + (int'(NIB) + 2) * ndone);
        k = (int'(NIB) + 2) * ndone;
        if (k > cyc) k = cyc;
        e = ref_op(ha[k], hb[k], hs[k], hc[k]);
        chk($sformatf("hold.sum%0d", ndone),  32'(bus.sum),  32'(e[W-1:0]));
        chk($sformatf("hold.cout%0d", ndone), 32'(bus.cout), 32'(e[W]));
        chk($sformatf("hold.ovf%0d", ndone),  32'(bus.ovf),  32'(e[W+1]));
        ndone++;
      end
    end
    chk("hold.done_count", ndone, 3);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold.drain_busy", 32'(bus.busy), 0);

    // Reset during the second RUN cycle
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h1111; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.partial_sum", 32'(bus.sum), 32'h0002);
    chk("rstmid.busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("rstmid.busy", 32'(bus.busy), 0);
    chk("rstmid.done", 32'(bus.done), 0);
    chk("rstmid.sum",  32'(bus.sum),  0);
    chk("rstmid.cout", 32'(bus.cout), 0);
    chk("rstmid.ovf",  32'(bus.ovf),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) spurious++;
    end
    chk("rstmid.no_done", spurious, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
